// File: rtl/lcd_bus_writer_if.sv
// Byte-request handshake from the upstream producer plus the HD44780-style
// LCD pins driven by lcd_bus_writer.
interface lcd_bus_writer_if;
  // Handshake: a byte moves on a rising edge where in_valid && in_ready.
  // in_ready only rises when the writer is idle. The producer holds in_valid,
  // in_rs and in_data steady until that edge.
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_data
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// Writes one byte at a time to a character LCD. It applies the setup, enable,
// hold and execution timing, and adds a longer wait after clear/home commands.
module lcd_bus_writer #(
  parameter int unsigned INIT_CYC      = 1_875_000,
  parameter int unsigned SETUP_CYC     = 5,
  parameter int unsigned EN_HIGH_CYC   = 32,
  parameter int unsigned HOLD_CYC      = 3,
  parameter int unsigned EXEC_CYC      = 5_000,
  parameter int unsigned LONG_EXEC_CYC = 205_000
) (
  input  logic               SYS_clk,
  input  logic               SYS_reset,
  lcd_bus_writer_if.slave    bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_IDLE    = 3'd1,
    S_SETUP   = 3'd2,
    S_PULSE   = 3'd3,
    S_HOLD    = 3'd4,
    S_EXEC    = 3'd5
  } state_t;

  localparam logic [20:0] INIT_M1  = 21'(INIT_CYC - 1);
  localparam logic [20:0] SETUP_M1 = 21'(SETUP_CYC - 1);
  localparam logic [20:0] EN_M1    = 21'(EN_HIGH_CYC - 1);
  localparam logic [20:0] HOLD_M1  = 21'(HOLD_CYC - 1);
  localparam logic [20:0] EXEC_M1  = 21'(EXEC_CYC - 1);
  localparam logic [20:0] LONG_M1  = 21'(LONG_EXEC_CYC - 1);

  state_t      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        en_q, en_d;
  logic        cnt_zero;
  logic        long_cmd;

  assign cnt_zero = (cnt_q == 21'd0);
  // Clear (0x01) and return-home (0x02/0x03) need the slow execution wait.
  assign long_cmd = !rs_q && (data_q[7:1] == 7'b0000000 || data_q[7:1] == 7'b0000001);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    if (state_q != S_IDLE && !cnt_zero) cnt_d = cnt_q - 21'd1;
    case (state_q)
      S_POWERUP: if (cnt_zero) state_d = S_IDLE;
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_M1;
          rs_d    = bus.in_rs;
          data_d  = bus.in_data;
        end
      end
      S_SETUP: if (cnt_zero) begin state_d = S_PULSE; cnt_d = EN_M1;   end
      S_PULSE: if (cnt_zero) begin state_d = S_HOLD;  cnt_d = HOLD_M1; end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_EXEC;
          cnt_d   = long_cmd ? LONG_M1 : EXEC_M1;
        end
      end
      S_EXEC: if (cnt_zero) state_d = S_IDLE;
      default: begin
        state_d = S_POWERUP;
        cnt_d   = INIT_M1;
      end
    endcase
    // Outputs follow the next state so every pin comes straight from a flop.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    en_d    = (state_d == S_PULSE);
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q <= S_POWERUP;
      cnt_q   <= INIT_M1;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_data = data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer with short timing parameters:
// INIT=10, SETUP=2, EN_HIGH=4, HOLD=2, EXEC=8, LONG_EXEC=20.
module tb_lcd_bus_writer;
  localparam int INIT = 10, SETUP = 2, EN_HIGH = 4, HOLD = 2, EXEC = 8, LONG_EXEC = 20;
  localparam int SHORT_SPAN = 1 + SETUP + EN_HIGH + HOLD + EXEC;       // 17
  localparam int LONG_SPAN  = 1 + SETUP + EN_HIGH + HOLD + LONG_EXEC;  // 29

  logic       SYS_clk = 1'b0;
  logic       SYS_reset;
  logic [2:0] dbg_state;

  lcd_bus_writer_if bus ();

  lcd_bus_writer #(
    .INIT_CYC(INIT), .SETUP_CYC(SETUP), .EN_HIGH_CYC(EN_HIGH),
    .HOLD_CYC(HOLD), .EXEC_CYC(EXEC), .LONG_EXEC_CYC(LONG_EXEC)
  ) dut (
    .SYS_clk  (SYS_clk),
    .SYS_reset(SYS_reset),
    .bus      (bus.slave),
    .dbg_state(dbg_state)
  );

  always #5 SYS_clk = ~SYS_clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         span;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},    32'(bus.lcd_en),   32'd0);
    chk({tag, "_rs"},    32'(bus.lcd_rs),   32'd0);
    chk({tag, "_data"},  32'(bus.lcd_data), 32'h00);
    chk({tag, "_rw"},    32'(bus.lcd_rw),   32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),     32'd1);
    chk({tag, "_state"}, 32'(dbg_state),    32'd0);
  endtask

  // Call at the negedge where reset was just dropped.
  task automatic check_powerup(input string tag);
    int rise = 0;
    int en_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge SYS_clk);
      if (bus.lcd_en) en_seen++;
      if (bus.in_ready) begin
        rise = k;
        break;
      end
    end
    chk({tag, "_ready_rise"}, 32'(rise), 32'(INIT));
    chk({tag, "_no_en"},      32'(en_seen), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (bus.in_ready) break;
      @(negedge SYS_clk);
    end
    chk({tag, "_wait_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_xfer(input int idx, input logic rs, input logic [7:0] d, input int span);
    logic [8:0] e;
    int en_first = 0;
    int en_cnt = 0;
    int ready_cyc = 0;
    int unstable = 0;
    int busy_bad = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in_rs    = rs;
    bus.in_data  = d;
    exp_q.push_back({rs, d});
    @(posedge SYS_clk);
    @(negedge SYS_clk);
    bus.in_valid = 1'b0;
    bus.in_rs    = ~rs;
    bus.in_data  = ~d;
    e = exp_q.pop_front();
    chk({tag, "_lcd_data"}, 32'(bus.lcd_data), 32'(e[7:0]));
    chk({tag, "_lcd_rs"},   32'(bus.lcd_rs),   32'(e[8]));
    chk({tag, "_ready_lo"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_rw"},       32'(bus.lcd_rw),   32'd0);
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge SYS_clk);
      if (bus.busy !== ~bus.in_ready) busy_bad++;
      if (bus.lcd_data !== e[7:0] || bus.lcd_rs !== e[8]) unstable++;
      if (bus.lcd_en) begin
        if (en_first == 0) en_first = k;
        en_cnt++;
      end
      if (bus.in_ready) begin
        ready_cyc = k;
        break;
      end
    end
    chk({tag, "_en_first"},  32'(en_first),  32'(1 + SETUP));
    chk({tag, "_en_width"},  32'(en_cnt),    32'(EN_HIGH));
    chk({tag, "_ready_cyc"}, 32'(ready_cyc), 32'(span));
    chk({tag, "_stable"},    32'(unstable),  32'd0);
    chk({tag, "_busy_inv"},  32'(busy_bad),  32'd0);
  endtask

  initial begin
    logic [7:0] bytes[3];
    int idx, last, en_bad;
    logic pend;

    vecs[0] = '{rs: 1'b1, data: 8'h53, span: SHORT_SPAN};
    vecs[1] = '{rs: 1'b0, data: 8'h01, span: LONG_SPAN};
    vecs[2] = '{rs: 1'b0, data: 8'h38, span: SHORT_SPAN};
    vecs[3] = '{rs: 1'b0, data: 8'h02, span: LONG_SPAN};
    vecs[4] = '{rs: 1'b0, data: 8'h03, span: LONG_SPAN};
    vecs[5] = '{rs: 1'b1, data: 8'h01, span: SHORT_SPAN};
    vecs[6] = '{rs: 1'b0, data: 8'h04, span: SHORT_SPAN};
    vecs[7] = '{rs: 1'b0, data: 8'h00, span: LONG_SPAN};

    // Reset while upstream already requests a byte.
    SYS_reset    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_rs    = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (3) @(posedge SYS_clk);
    @(negedge SYS_clk);
    chk_reset_outputs("rst");
    SYS_reset = 1'b0;
    check_powerup("pwr");
    @(negedge SYS_clk);
    chk("held_valid_data",  32'(bus.lcd_data), 32'hAA);
    chk("held_valid_rs",    32'(bus.lcd_rs),   32'd1);
    chk("held_valid_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 8; i++) do_xfer(i, vecs[i].rs, vecs[i].data, vecs[i].span);

    // Back-to-back "T","O","I" with in_valid held high throughout.
    wait_ready("b2b");
    bytes[0] = 8'h54;
    bytes[1] = 8'h4F;
    bytes[2] = 8'h49;
    bus.in_valid = 1'b1;
    bus.in_rs    = 1'b1;
    bus.in_data  = bytes[0];
    idx = 0; last = 0; en_bad = 0; pend = 1'b0;
    for (int c = 0; c < 200 && idx < 3; c++) begin
      if (pend) begin
        chk($sformatf("b2b%0d_data", idx), 32'(bus.lcd_data), 32'(bytes[idx]));
        chk($sformatf("b2b%0d_one_ready", idx), 32'(bus.in_ready), 32'd0);
        idx++;
        pend = 1'b0;
        if (idx < 3) bus.in_data = bytes[idx];
        else bus.in_valid = 1'b0;
      end
      if (bus.lcd_en && idx > 0 && bus.lcd_data !== bytes[idx-1]) en_bad++;
      if (idx < 3 && bus.in_ready) begin
        if (idx > 0) chk($sformatf("b2b%0d_spacing", idx), 32'(c - last), 32'(SHORT_SPAN));
        last = c;
        pend = 1'b1;
      end
      if (idx < 3) @(negedge SYS_clk);
    end
    chk("b2b_count",     32'(idx),    32'd3);
    chk("b2b_en_stable", 32'(en_bad), 32'd0);

    // Reset during the second PULSE cycle.
    wait_ready("pr");
    bus.in_valid = 1'b1;
    bus.in_rs    = 1'b1;
    bus.in_data  = 8'h55;
    @(posedge SYS_clk);
    @(negedge SYS_clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.lcd_en) break;
      @(negedge SYS_clk);
    end
    chk("pr_pulse_start", 32'(bus.lcd_en), 32'd1);
    @(negedge SYS_clk);
    chk("pr_pulse_2nd", 32'(bus.lcd_en), 32'd1);
    SYS_reset = 1'b1;
    @(posedge SYS_clk);
    #1;
    chk("pr_en_drop", 32'(bus.lcd_en), 32'd0);
    @(negedge SYS_clk);
    chk_reset_outputs("pr_rst");
    SYS_reset = 1'b0;
    check_powerup("pr_pwr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_bus_writer.md
LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

Interface
REQ-001 Parameter INIT_CYC, default 1_875_000: power-up wait, 15 ms at 125 MHz.
REQ-002 Parameter SETUP_CYC, default 5: RS/DATA setup before EN rises.
REQ-003 Parameter EN_HIGH_CYC, default 32: EN high width.
REQ-004 Parameter HOLD_CYC, default 3: RS/DATA hold after EN falls.
REQ-005 Parameter EXEC_CYC, default 5_000: short-instruction and data execution wait, 40 us.
REQ-006 Parameter LONG_EXEC_CYC, default 205_000: clear/home execution wait, 1.64 ms.
REQ-007 SYS_clk  in  1  sole clock, all logic on rising edge.
REQ-008 SYS_reset  in  1  synchronous, active-high reset.
REQ-009 in_valid  in  1  upstream byte request.
REQ-010 in_ready  out  1  block can accept a byte this cycle.
REQ-011 in_rs  in  1  0 = instruction, 1 = character data.
REQ-012 in_data  in  8  byte to write.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 lcd_rs  out  1  LCD register select.
REQ-015 lcd_rw  out  1  LCD read/write, constant 0.
REQ-016 lcd_en  out  1  LCD enable strobe.
REQ-017 lcd_data  out  8  LCD data bus.

Function
REQ-018 The block SHALL use one clock (SYS_clk) with a synchronous, active-high reset (SYS_reset); no other clock or asynchronous reset SHALL exist.
REQ-019 States SHALL be POWERUP, IDLE, SETUP, PULSE, HOLD and EXEC; all outputs SHALL be registered.
REQ-020 Each timed phase SHALL load a 21-bit down-counter with N-1 on entry and exit when the counter is 0, so the phase lasts exactly N cycles; every parameter SHALL be >= 1 and < 2^21.
REQ-021 POWERUP SHALL last INIT_CYC cycles, then go to IDLE.
REQ-022 in_ready SHALL be 1 only in IDLE; a transfer SHALL occur on an edge where in_valid and in_ready are both 1.
REQ-023 On a transfer, in_rs and in_data SHALL drive lcd_rs and lcd_data, in_ready SHALL go 0 and the state SHALL go to SETUP, all at that same edge.
REQ-024 SETUP SHALL hold lcd_en = 0 for SETUP_CYC cycles.
REQ-025 PULSE SHALL hold lcd_en = 1 for exactly EN_HIGH_CYC cycles.
REQ-026 HOLD SHALL hold lcd_en = 0 for HOLD_CYC cycles.
REQ-027 EXEC SHALL wait LONG_EXEC_CYC cycles when the latched byte has rs = 0 and data[7:1] = 7'b0000000 (clear 0x01) or 7'b0000001 (home 0x02/0x03); otherwise it SHALL wait EXEC_CYC cycles; afterwards the state SHALL go to IDLE.
REQ-028 lcd_rs and lcd_data SHALL stay stable from the transfer edge until the next transfer; they SHALL NOT change in EXEC or IDLE.
REQ-029 in_valid asserted while in_ready = 0 SHALL be ignored; upstream holds it, and it is accepted on the first IDLE cycle.
REQ-030 Minimum spacing between transfers SHALL be 1 + SETUP_CYC + EN_HIGH_CYC + HOLD_CYC + wait cycles, where wait is EXEC_CYC or LONG_EXEC_CYC per REQ-027; back-to-back transfers SHALL work with no idle gap beyond one IDLE cycle.
REQ-031 lcd_en SHALL be 1 only in PULSE, and it SHALL be glitch-free because it is a direct register output.
REQ-032 busy SHALL equal the inverse of in_ready at all times.

Reset
REQ-033 While SYS_reset = 1 at an edge, state SHALL be set to POWERUP, the counter to INIT_CYC-1, and outputs to lcd_en = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 8'h00, in_ready = 0, busy = 1.
REQ-034 Reset asserted mid-transfer (including during PULSE) SHALL drop lcd_en at that same edge, discard the byte, and restart the full INIT_CYC wait.
REQ-035 in_valid SHALL be ignored during reset and during POWERUP.

Verification (INIT=10, SETUP=2, EN_HIGH=4, HOLD=2, EXEC=8, LONG_EXEC=20)
REQ-036 Release reset with in_valid = 1 -> in_ready rises exactly 10 cycles after the reset deassertion edge; no lcd_en activity before that.
REQ-037 Write rs = 1, data = 0x53 ("S") -> lcd_data = 0x53 and lcd_rs = 1 from the transfer edge; lcd_en high cycles 3-6 after the transfer; in_ready returns at cycle 1+2+4+2+8 = 17.
REQ-038 Write rs = 0, data = 0x01, then rs = 0, data = 0x38 -> first wait is 20 cycles, second is 8; both lcd_en pulses are exactly 4 cycles wide.
REQ-039 Write rs = 0, data = 0x02 and rs = 0, data = 0x03 -> long wait; rs = 1, data = 0x01 -> short wait.
REQ-040 Hold in_valid high continuously with bytes "T","O","I" -> three transfers, each with exactly one in_ready = 1 cycle; lcd_data never changes while lcd_en = 1.
REQ-041 Assert SYS_reset during the 2nd cycle of PULSE -> lcd_en = 0 at that edge, all outputs at reset values, then full INIT wait before in_ready = 1.
